// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the video timing generator: count width, standard mode
// porch/sync figures and the total-length helper.
package vga_timing_pkg;

  localparam int COUNT_W = 12;
  typedef logic [COUNT_W-1:0] count_t;

  // 1280x960 @ 60 Hz, 108 MHz pixel clock
  localparam int M1280_H_VISIBLE = 1280;
  localparam int M1280_H_FRONT   = 96;
  localparam int M1280_H_SYNC    = 112;
  localparam int M1280_H_BACK    = 312;
  localparam int M1280_V_VISIBLE = 960;
  localparam int M1280_V_FRONT   = 1;
  localparam int M1280_V_SYNC    = 3;
  localparam int M1280_V_BACK    = 36;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int M640_H_VISIBLE = 640;
  localparam int M640_H_FRONT   = 16;
  localparam int M640_H_SYNC    = 96;
  localparam int M640_H_BACK    = 48;
  localparam int M640_V_VISIBLE = 480;
  localparam int M640_V_FRONT   = 10;
  localparam int M640_V_SYNC    = 2;
  localparam int M640_V_BACK    = 33;

  function automatic count_t calc_total(input int visible, input int front,
                                        input int sync, input int back);
    return count_t'(visible + front + sync + back);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the generator to the pattern/colour stage.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  count_t     h_count;
  count_t     v_count;
  logic       display_en;
  logic       h_sync;
  logic       v_sync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output h_count, v_count, display_en, h_sync, v_sync,
           line_start, frame_start, frame_count
  );

  modport slave (
    input h_count, v_count, display_en, h_sync, v_sync,
          line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth register pipeline with a per-bit reset value; depth 0 is a wire.
module sync_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running h/v pixel counters with visible flag, line/frame markers and
// sync pulses delayed to line up with the registered colour stage downstream.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = M1280_H_VISIBLE,
  parameter int H_FRONT    = M1280_H_FRONT,
  parameter int H_SYNC     = M1280_H_SYNC,
  parameter int H_BACK     = M1280_H_BACK,
  parameter int V_VISIBLE  = M1280_V_VISIBLE,
  parameter int V_FRONT    = M1280_V_FRONT,
  parameter int V_SYNC     = M1280_V_SYNC,
  parameter int V_BACK     = M1280_V_BACK,
  parameter int H_POL      = 1,
  parameter int V_POL      = 1,
  parameter int SYNC_DELAY = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  vga_timing_gen_if.master vid
);

  localparam count_t H_TOTAL  = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam count_t V_TOTAL  = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam count_t H_LAST   = H_TOTAL - count_t'(1);
  localparam count_t V_LAST   = V_TOTAL - count_t'(1);
  localparam count_t H_VIS    = count_t'(H_VISIBLE);
  localparam count_t V_VIS    = count_t'(V_VISIBLE);
  localparam count_t HS_START = count_t'(H_VISIBLE + H_FRONT);
  localparam count_t HS_END   = count_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam count_t VS_START = count_t'(V_VISIBLE + V_FRONT);
  localparam count_t VS_END   = count_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic   H_ACT    = (H_POL != 0);
  localparam logic   V_ACT    = (V_POL != 0);

  count_t     h_q, v_q;
  count_t     h_nxt, v_nxt;
  logic       h_wrap;
  logic       de_nxt, ls_nxt, fs_nxt;
  logic       hs_raw_nxt, vs_raw_nxt;
  logic       display_q, line_q, frame_q;
  logic [7:0] frame_cnt_q;
  logic [1:0] sync_raw_q;
  logic [1:0] sync_dly;

  // Everything is decoded from the next-state counts so the registered flags
  // land in the same cycle as the counts they describe.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_nxt  = h_wrap ? '0 : h_q + count_t'(1);
    v_nxt  = v_q;
    if (h_wrap) begin
      v_nxt = (v_q == V_LAST) ? '0 : v_q + count_t'(1);
    end
    de_nxt     = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    ls_nxt     = (h_nxt == '0);
    fs_nxt     = ls_nxt && (v_nxt == '0);
    hs_raw_nxt = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? H_ACT : ~H_ACT;
    vs_raw_nxt = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? V_ACT : ~V_ACT;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      display_q   <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= '0;
      sync_raw_q  <= {~V_ACT, ~H_ACT};
    end else begin
      h_q         <= h_nxt;
      v_q         <= v_nxt;
      display_q   <= de_nxt;
      line_q      <= ls_nxt;
      frame_q     <= fs_nxt;
      frame_cnt_q <= frame_cnt_q + {7'd0, fs_nxt};
      sync_raw_q  <= {vs_raw_nxt, hs_raw_nxt};
    end
  end

  sync_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .WIDTH   (2),
    .RST_VAL ({~V_ACT, ~H_ACT})
  ) u_sync_dly (
    .clk (clk_in),
    .rst (reset),
    .d   (sync_raw_q),
    .q   (sync_dly)
  );

  assign vid.h_count     = h_q;
  assign vid.v_count     = v_q;
  assign vid.display_en  = display_q;
  assign vid.line_start  = line_q;
  assign vid.frame_start = frame_q;
  assign vid.frame_count = frame_cnt_q;
  assign vid.h_sync      = sync_dly[0];
  assign vid.v_sync      = sync_dly[1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 1280x960 mode for line timing, small 12x8 mode for
// vertical timing, sync polarity/delay, reset and frame counter wrap.
module tb_vga_timing_gen;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;

  always #5 clk_in = ~clk_in;

  vga_timing_gen_if v0 ();
  vga_timing_gen_if v1 ();
  vga_timing_gen_if v2 ();

  // Full mode, positive syncs, one delay stage
  vga_timing_gen dut0 (.clk_in(clk_in), .reset(reset), .vid(v0));

  // Small mode 12x8, active-low syncs, no delay
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .H_POL(0), .V_POL(0), .SYNC_DELAY(0)
  ) dut1 (.clk_in(clk_in), .reset(reset), .vid(v1));

  // Small mode 12x8, active-high syncs, three delay stages
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .H_POL(1), .V_POL(1), .SYNC_DELAY(3)
  ) dut2 (.clk_in(clk_in), .reset(reset), .vid(v2));

  task automatic step();
    @(posedge clk_in);
    #1;
    n++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    checks++; if (v1.h_sync !== 1'b1) begin errors++; $display("FAIL rst_hold_hs1 got %b want 1", v1.h_sync); end
    checks++; if (v1.v_sync !== 1'b1) begin errors++; $display("FAIL rst_hold_vs1 got %b want 1", v1.v_sync); end
    checks++; if (v0.h_count !== 12'd0) begin errors++; $display("FAIL rst_hold_h0 got %0d want 0", v0.h_count); end
    apply_reset();
    checks++; if (v0.h_count !== 12'd0) begin errors++; $display("FAIL rst_h0 got %0d want 0", v0.h_count); end
    checks++; if (v0.v_count !== 12'd0) begin errors++; $display("FAIL rst_v0 got %0d want 0", v0.v_count); end
    checks++; if (v0.display_en !== 1'b0) begin errors++; $display("FAIL rst_de0 got %b want 0", v0.display_en); end
    checks++; if (v0.line_start !== 1'b0) begin errors++; $display("FAIL rst_ls0 got %b want 0", v0.line_start); end
    checks++; if (v0.frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs0 got %b want 0", v0.frame_start); end
    checks++; if (v0.frame_count !== 8'd0) begin errors++; $display("FAIL rst_fc0 got %0d want 0", v0.frame_count); end
    checks++; if ({v0.v_sync, v0.h_sync} !== 2'b00) begin errors++; $display("FAIL rst_sync0 got %b want 00", {v0.v_sync, v0.h_sync}); end
    checks++; if ({v1.v_sync, v1.h_sync} !== 2'b11) begin errors++; $display("FAIL rst_sync1 got %b want 11", {v1.v_sync, v1.h_sync}); end
    checks++; if ({v2.v_sync, v2.h_sync} !== 2'b00) begin errors++; $display("FAIL rst_sync2 got %b want 00", {v2.v_sync, v2.h_sync}); end
    step();
    checks++; if (v0.h_count !== 12'd1) begin errors++; $display("FAIL first_edge_h got %0d want 1", v0.h_count); end
    checks++; if (v0.display_en !== 1'b1) begin errors++; $display("FAIL first_edge_de got %b want 1", v0.display_en); end
    checks++; if (v0.frame_start !== 1'b0) begin errors++; $display("FAIL first_edge_fs got %b want 0", v0.frame_start); end
  endtask

  // Three lines of the full mode: h_sync placement/width, line period, visible width.
  task automatic test_default_line();
    int   rise_h = -1;
    int   hs_width = 0;
    int   de_v1 = 0;
    int   ls_first = -1;
    int   ls_second = -1;
    int   fs_seen = 0;
    int   track_err = 0;
    int   de_blank_err = 0;
    logic hs_prev;
    apply_reset();
    hs_prev = v0.h_sync;
    while (n < 3 * 1800 + 5) begin
      step();
      if (v0.h_count !== 12'(n % 1800) || v0.v_count !== 12'(n / 1800)) track_err++;
      if (v0.h_sync === 1'b1 && hs_prev === 1'b0 && rise_h < 0) rise_h = int'(v0.h_count);
      if (v0.h_sync === 1'b1 && v0.v_count == 12'd1) hs_width++;
      if (v0.display_en === 1'b1 && v0.v_count == 12'd1) de_v1++;
      if (v0.display_en === 1'b1 && v0.h_count >= 12'd1280) de_blank_err++;
      if (v0.line_start === 1'b1) begin
        if (ls_first < 0) ls_first = n;
        else if (ls_second < 0) ls_second = n;
      end
      if (v0.frame_start === 1'b1) fs_seen++;
      hs_prev = v0.h_sync;
    end
    checks++; if (track_err != 0) begin errors++; $display("FAIL h_v_track mismatches %0d want 0", track_err); end
    checks++; if (rise_h != 1377) begin errors++; $display("FAIL hs_rise_at_h got %0d want 1377", rise_h); end
    checks++; if (hs_width != 112) begin errors++; $display("FAIL hs_width got %0d want 112", hs_width); end
    checks++; if (de_v1 != 1280) begin errors++; $display("FAIL de_per_line got %0d want 1280", de_v1); end
    checks++; if (de_blank_err != 0) begin errors++; $display("FAIL de_in_blank got %0d want 0", de_blank_err); end
    checks++; if (ls_first != 1800) begin errors++; $display("FAIL ls_first got %0d want 1800", ls_first); end
    checks++; if (ls_second - ls_first != 1800) begin errors++; $display("FAIL ls_period got %0d want 1800", ls_second - ls_first); end
    checks++; if (fs_seen != 0) begin errors++; $display("FAIL fs_before_wrap got %0d want 0", fs_seen); end
  endtask

  // Two small-mode frames, checked every cycle against a cycle-count model.
  task automatic test_small_sync();
    int   eh, ev, m;
    logic e_de, e_ls, e_fs, e_hs1, e_vs1, e_hs2, e_vs2;
    apply_reset();
    for (int k = 0; k < 2 * 96; k++) begin
      eh    = n % 12;
      ev    = (n / 12) % 8;
      e_de  = (n != 0) && (eh < 8) && (ev < 4);
      e_ls  = (n != 0) && (eh == 0);
      e_fs  = e_ls && (ev == 0);
      e_hs1 = (eh == 9) ? 1'b0 : 1'b1;
      e_vs1 = (ev == 5) ? 1'b0 : 1'b1;
      m     = n - 3;
      e_hs2 = (m >= 0) && ((m % 12) == 9);
      e_vs2 = (m >= 0) && (((m / 12) % 8) == 5);
      checks++; if (v1.h_count !== 12'(eh)) begin errors++; $display("FAIL s_h n=%0d got %0d want %0d", n, v1.h_count, eh); end
      checks++; if (v1.v_count !== 12'(ev)) begin errors++; $display("FAIL s_v n=%0d got %0d want %0d", n, v1.v_count, ev); end
      checks++; if (v1.display_en !== e_de) begin errors++; $display("FAIL s_de n=%0d got %b want %b", n, v1.display_en, e_de); end
      checks++; if (v1.line_start !== e_ls) begin errors++; $display("FAIL s_ls n=%0d got %b want %b", n, v1.line_start, e_ls); end
      checks++; if (v1.frame_start !== e_fs) begin errors++; $display("FAIL s_fs n=%0d got %b want %b", n, v1.frame_start, e_fs); end
      checks++; if (v1.frame_count !== 8'(n / 96)) begin errors++; $display("FAIL s_fc n=%0d got %0d want %0d", n, v1.frame_count, n / 96); end
      checks++; if (v1.h_sync !== e_hs1) begin errors++; $display("FAIL s_hs_d0 n=%0d got %b want %b", n, v1.h_sync, e_hs1); end
      checks++; if (v1.v_sync !== e_vs1) begin errors++; $display("FAIL s_vs_d0 n=%0d got %b want %b", n, v1.v_sync, e_vs1); end
      checks++; if (v2.h_sync !== e_hs2) begin errors++; $display("FAIL s_hs_d3 n=%0d got %b want %b", n, v2.h_sync, e_hs2); end
      checks++; if (v2.v_sync !== e_vs2) begin errors++; $display("FAIL s_vs_d3 n=%0d got %b want %b", n, v2.v_sync, e_vs2); end
      step();
    end
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    while (n < 255 * 96) step();
    checks++; if (v1.frame_count !== 8'd255) begin errors++; $display("FAIL fc_255 got %0d want 255", v1.frame_count); end
    checks++; if (v1.frame_start !== 1'b1) begin errors++; $display("FAIL fs_at_255 got %b want 1", v1.frame_start); end
    while (n < 256 * 96 - 1) step();
    checks++; if ({v1.h_count, v1.v_count} !== {12'd11, 12'd7}) begin errors++; $display("FAIL last_pixel got h=%0d v=%0d want h=11 v=7", v1.h_count, v1.v_count); end
    checks++; if (v1.frame_count !== 8'd255) begin errors++; $display("FAIL fc_before_wrap got %0d want 255", v1.frame_count); end
    step();
    checks++; if ({v1.h_count, v1.v_count} !== 24'd0) begin errors++; $display("FAIL wrap_hv got h=%0d v=%0d want 0 0", v1.h_count, v1.v_count); end
    checks++; if ({v1.line_start, v1.frame_start} !== 2'b11) begin errors++; $display("FAIL wrap_pulses got %b want 11", {v1.line_start, v1.frame_start}); end
    checks++; if (v1.frame_count !== 8'd0) begin errors++; $display("FAIL fc_wrap got %0d want 0", v1.frame_count); end
    step();
    checks++; if ({v1.line_start, v1.frame_start} !== 2'b00) begin errors++; $display("FAIL after_wrap_pulses got %b want 00", {v1.line_start, v1.frame_start}); end
    while (n < 260 * 96) step();
    checks++; if (v1.frame_count !== 8'd4) begin errors++; $display("FAIL fc_260 got %0d want 4", v1.frame_count); end
  endtask

  task automatic test_mid_reset();
    int fs_at = -1;
    apply_reset();
    while (n < 700) step();
    checks++; if (v0.h_count !== 12'd700) begin errors++; $display("FAIL pre_h0 got %0d want 700", v0.h_count); end
    checks++; if ({v1.frame_count, v1.h_count, v1.v_count} !== {8'd7, 12'd4, 12'd2}) begin errors++; $display("FAIL pre_small got fc=%0d h=%0d v=%0d want 7 4 2", v1.frame_count, v1.h_count, v1.v_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({v0.h_count, v0.v_count} !== 24'd0) begin errors++; $display("FAIL async_hv got h=%0d v=%0d want 0 0", v0.h_count, v0.v_count); end
    checks++; if (v0.display_en !== 1'b0) begin errors++; $display("FAIL async_de got %b want 0", v0.display_en); end
    checks++; if (v1.frame_count !== 8'd0) begin errors++; $display("FAIL async_fc got %0d want 0", v1.frame_count); end
    checks++; if ({v1.v_sync, v1.h_sync} !== 2'b11) begin errors++; $display("FAIL async_sync1 got %b want 11", {v1.v_sync, v1.h_sync}); end
    checks++; if ({v1.line_start, v1.frame_start} !== 2'b00) begin errors++; $display("FAIL async_pulses got %b want 00", {v1.line_start, v1.frame_start}); end
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    n = 0;
    step();
    checks++; if (v0.h_count !== 12'd1) begin errors++; $display("FAIL rel_h got %0d want 1", v0.h_count); end
    if (v1.frame_start === 1'b1) fs_at = n;
    while (fs_at < 0 && n < 200) begin
      step();
      if (v1.frame_start === 1'b1) fs_at = n;
    end
    checks++; if (fs_at != 96) begin errors++; $display("FAIL first_fs got %0d want 96", fs_at); end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_small_sync();
    test_frame_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Video timing generator feeding the pattern/colour stage: free-running horizontal and vertical pixel counters, a visible-region flag, sync pulses and frame/line markers for the 1280x960@60 Hz mode (108 MHz pixel clock). The colour stage registers its RGB output one cycle after reading `h_count`/`v_count`/`display_en`. This block therefore delays `h_sync`/`v_sync` by a parameterised number of cycles so sync stays pixel-aligned with the registered colour at the connector.

## Interface
Parameters:
- `H_VISIBLE`, 1280, active pixels per line
- `H_FRONT`, 96, horizontal front porch (pixels)
- `H_SYNC`, 112, horizontal sync width
- `H_BACK`, 312, horizontal back porch; line total 1800
- `V_VISIBLE`, 960, active lines per frame
- `V_FRONT`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vertical sync width
- `V_BACK`, 36, vertical back porch; frame total 1000
- `H_POL`, 1, h_sync active level (1 = positive)
- `V_POL`, 1, v_sync active level
- `SYNC_DELAY`, 1, extra register stages on h_sync/v_sync, legal 0..3

Ports:
- `clk_in`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `h_count`  out  12  current pixel column, 0..H_TOTAL-1
- `v_count`  out  12  current line, 0..V_TOTAL-1
- `display_en`  out  1  high while h_count<H_VISIBLE and v_count<V_VISIBLE
- `h_sync`  out  1  horizontal sync, delayed SYNC_DELAY cycles
- `v_sync`  out  1  vertical sync, delayed SYNC_DELAY cycles
- `line_start`  out  1  one-cycle pulse when h_count==0
- `frame_start`  out  1  one-cycle pulse when h_count==0 and v_count==0
- `frame_count`  out  8  frames started since reset, wraps

## Operation
- H_TOTAL = sum of the four H params; V_TOTAL likewise. All arithmetic is 12-bit unsigned. H_TOTAL and V_TOTAL must be ≤4095.
- h counter: +1 every clock; at H_TOTAL-1 it wraps to 0 and v increments. v at V_TOTAL-1 with h wrap goes to 0.
- All outputs are registered. display_en, line_start, frame_start and raw syncs are decoded from the next-state counter values, so they are coincident with the h_count/v_count they describe.
- Raw h_sync is active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). Raw v_sync is active for full lines v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), switching at h==0.
- Raw syncs pass through SYNC_DELAY stages. With SYNC_DELAY=0 they are coincident with counts.
- frame_count increments in the same cycle frame_start is asserted; 255 wraps to 0.
- Reset (any time, including mid-frame) immediately forces:
  - h_count=0, v_count=0
  - display_en=0, line_start=0, frame_start=0, frame_count=0
  - all sync delay stages at inactive level (~H_POL / ~V_POL)
- Consequence of reset behaviour: pixel (0,0) of the first frame after reset is blanked. The first clock edge after deassertion yields h_count=1, display_en=1. No frame_start is produced until the first wrap.

## Timing
- Latency: counts/display_en/markers 0 cycles relative to each other. Syncs lag counts by exactly SYNC_DELAY cycles.
- h_sync asserts SYNC_DELAY cycles after h_count reaches 1376 and deasserts SYNC_DELAY cycles after h_count reaches 1488 (defaults).
- v_sync asserts at (h=0, v=961)+SYNC_DELAY and deasserts at (h=0, v=964)+SYNC_DELAY.
- Line period 1800 cycles; frame period 1 800 000 cycles.
- Simultaneous wrap: at h=H_TOTAL-1, v=V_TOTAL-1, the next cycle has h=0, v=0, line_start=frame_start=1 and frame_count incremented.

## Structure
- Package `vga_timing_pkg`: 1280x960 and 640x480 mode constants, H_TOTAL/V_TOTAL computation, 12-bit count width constant.
- Sub-module `sync_delay_line`: parameterised depth (0..3), width 2, per-bit reset value. Used for the sync pipeline.

## Test plan
- Default params, run 2 frames: line_start every 1800 cycles, frame_start every 1 800 000 cycles, display_en high 1280 cycles/line on lines 0..959 only.
- SYNC_DELAY=1: h_sync rises exactly 1 cycle after h_count==1376 and is high for 112 cycles. v_sync is high for 3×1800 cycles starting line 961 +1 cycle.
- SYNC_DELAY=0, H_POL=0, V_POL=0: syncs low-active, coincident with counts, idle high during and after reset.
- Reset asserted mid-frame (h=700, v=500) without a clock edge: all outputs go to reset values immediately. After release, h_count=1 on the first edge and the first frame_start occurs at the first wrap.
- Small mode (H 8/1/1/2, V 4/1/1/2), 260 frames: frame_count wraps 255→0 and the simultaneous h/v wrap produces both pulses in one cycle.
